// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous RAM between the
// instruction-fetch port and the load/store data port. Each access is issued,
// waited on for MEM_LATENCY cycles when it is a read, then acknowledged.
// Store byte lanes and sub-word load extraction/extension are handled here.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate the grant when both ports
// request; without it the data port always wins.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_ext,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_gnt_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_ext;
  logic [31:0]       r_wdata;
  logic              r_mis;
  logic [2:0]        r_cnt;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;
  logic              w_start;
  logic              w_pick_d;
  logic              w_d_mis;
  logic              w_store_issue;

  // Byte-lane enables for a store of the given size at the given offset.
  function automatic logic [3:0] f_lanes(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b0001 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it might land in.
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b01:   return {2{d[15:0]}};
      2'b10:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [1:0] a,
                                         input logic [1:0] size, input logic ext);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b01:   return ext ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   return ext ? {24'h000000, b} : {{24{b[7]}}, b};
      default: return rd;
    endcase
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // Remember which port was granted last so contention alternates.
  always_ff @(posedge clk) begin
    if (rst)
      r_last_d <= 1'b0;
    else if (r_state == S_IDLE && w_start)
      r_last_d <= w_pick_d;
  end

  assign w_pick_d = d_req && (!if_req || !r_last_d);
`else
  assign w_pick_d = d_req;
`endif

  assign w_start = d_req || if_req;
  assign w_d_mis = (d_size == 2'b11) ||
                   (d_size == 2'b00 && d_addr[1:0] != 2'b00) ||
                   (d_size == 2'b01 && d_addr[0]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state sequencing: issue, wait on reads, acknowledge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = (w_pick_d && w_d_mis) ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = r_we ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == LAT_LAST) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the winning request's fields when it is sampled in IDLE.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_start) begin
      r_gnt_d <= w_pick_d;
      r_mis   <= w_pick_d && w_d_mis;
      r_addr  <= w_pick_d ? d_addr : if_addr;
      r_we    <= w_pick_d && d_we;
      r_size  <= w_pick_d ? d_size : 2'b00;
      r_ext   <= d_ext;
      r_wdata <= d_wdata;
    end
  end

  // Read-latency counter and read-data capture; rdata holds between acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start && w_pick_d && w_d_mis) r_d_rdata <= 32'h0;
        S_ISSUE: r_cnt <= 3'd0;
        S_WAIT: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == LAT_LAST) begin
            if (r_gnt_d)
              r_d_rdata <= f_load(mem_rdata, r_addr[1:0], r_size, r_ext);
            else
              r_if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_store_issue = (r_state == S_ISSUE) && r_we;

  // Memory strobes only in ISSUE; acks only in DONE.
  always_comb begin
    mem_en     = (r_state == S_ISSUE);
    mem_addr   = (r_state == S_ISSUE) ? r_addr[ADDR_W-1:2] : '0;
    mem_we     = w_store_issue ? f_lanes(r_size, r_addr[1:0]) : 4'b0000;
    mem_wdata  = w_store_issue ? f_wdata(r_size, r_wdata) : 32'h0;
    if_ack     = (r_state == S_DONE) && !r_gnt_d;
    d_ack      = (r_state == S_DONE) && r_gnt_d;
    d_misalign = (r_state == S_DONE) && r_gnt_d && r_mis;
    if_rdata   = r_if_rdata;
    d_rdata    = r_d_rdata;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported synchronous data/instruction RAM between the CPU instruction-fetch port and the load/store data port.
- Arbitrates between the two requesters and sequences each access (issue, wait, complete).
- Generates byte-lane write enables from the control unit's memDataSize/memBitExt encoding, and aligns, sign-extends or zero-extends sub-word load data.
- Sits between the CPU core and the SoC memory.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports.
- MEM_LATENCY, 1, cycles from mem_en high to mem_rdata valid (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; transaction complete.
- if_rdata  out  32  fetched word; valid with if_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_size  in  2  00 = word, 01 = half, 10 = byte, 11 = invalid.
- d_ext  in  1  0 = sign-extend, 1 = zero-extend (loads only).
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  extended load data; valid with d_ack.
- d_misalign  out  1  valid with d_ack; access was rejected.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte-lane write enables; lane i = bits [8i+7:8i].
- mem_addr  out  ADDR_W-2  word address (byte address [ADDR_W-1:2]).
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data.

Behaviour:
- Reset: state IDLE and all outputs 0. Any in-flight transaction is discarded with no ack; the wait counter clears.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: samples both requests.
  - Fixed priority: data port wins over fetch.
  - The winner's address, size, extend, write-enable and data are registered. Next state is ISSUE, or DONE for a misaligned data access.
- ISSUE (exactly 1 cycle):
  - mem_en = 1 and mem_addr = registered address [ADDR_W-1:2].
  - Stores drive mem_we and mem_wdata. Next state is DONE for stores, WAIT for loads and fetches.
- WAIT: counts MEM_LATENCY cycles after ISSUE, then captures the aligned/extended read data and moves to DONE. mem_en = 0 throughout.
- DONE (1 cycle): the granted port's ack = 1 with registered data. Both requests are ignored. Next state is IDLE.
- Latency from request sampled in IDLE (cycle 0):
  - Store ack at cycle 2.
  - Load or fetch ack at cycle 2 + MEM_LATENCY.
  - Misaligned ack at cycle 1.
- Requester protocol: hold req and all fields stable until ack. Drop req in the cycle after ack, or keep it high to start a new transaction, which is sampled in IDLE.
- Store lanes (little-endian):
  - word: mem_we = 1111.
  - half: 0011 if addr[1] = 0, else 1100; wdata = {2{d_wdata[15:0]}}.
  - byte: mem_we = 0001 << addr[1:0]; wdata = {4{d_wdata[7:0]}}.
- Load extraction: selects the byte or half by addr[1:0] / addr[1], then extends to 32 bits per d_ext.
- Misalignment, detected in IDLE, raises d_misalign = 1 with d_ack. Conditions:
  - word with addr[1:0] ≠ 0;
  - half with addr[0] ≠ 0;
  - d_size = 11.
- A misaligned access causes no memory access (mem_en stays 0) and returns d_rdata = 0.
- Fetch is always treated as a word access. A fetch with if_addr[1:0] ≠ 0 still reads the containing word; bits [1:0] are ignored.
- Simultaneous if_req and d_req in IDLE: data is served first; fetch is sampled at the next IDLE.
- Ack timing: if_ack and d_ack are never high in the same cycle. rdata outputs hold their value until the next ack for that port.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register (reset = fetch) is added. When both requests are present, the port not granted last wins; a single request is granted immediately.
- Undefined: fixed data-over-fetch priority as described above. Fetch can starve under continuous d_req; this is acceptable for the single-issue core.

Test Plan:
- Load byte, sign-extend, MEM_LATENCY = 1, from the word at 0x100:
  - Setup: mem word at 0x100 = 0x8033_44F0; d_req with d_addr = 0x103, d_size = 10, d_ext = 0.
  - Expect: mem_en at cycle 1; d_ack at cycle 3 with d_rdata = 0xFFFF_FF80.
- Same load with d_ext = 1 -> d_rdata = 0x0000_0080.
- Store half:
  - Stimulus: d_we = 1, d_addr = 0x202, d_size = 01, d_wdata = 0x1234_ABCD.
  - Expect: mem_we = 1100 and mem_wdata = 0xABCD_ABCD at cycle 1; d_ack at cycle 2.
- Misaligned word load:
  - Stimulus: d_addr = 0x301, d_size = 00.
  - Expect: mem_en stays 0; d_ack with d_misalign = 1 and d_rdata = 0 at cycle 1.
- Contention:
  - Stimulus: if_req and d_req both high at cycle 0, both loads.
  - Expect: d_ack at cycle 3, then fetch issues with if_ack at cycle 7. Under ARB_ROUND_ROBIN_EN with last grant = data, fetch is served first instead.
- Reset mid-operation:
  - Stimulus: assert rst in WAIT with MEM_LATENCY = 4.
  - Expect: no ack; all outputs 0 the next cycle; a request held through reset release is served normally.
